// File: rtl/prim_clock_div.sv
// prim_clock_div: even-integer clock divider with 50% duty, scanmode bypass and optional BUFG stage.
// Optional feature macro PRIM_CLOCK_DIV_STEP_DOWN_EN adds a handshaked switch to Divisor/2.
module prim_clock_div #(
    parameter int unsigned Divisor    = 4,
    parameter bit          NoFpgaBufG = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scanmode_i,
`ifdef PRIM_CLOCK_DIV_STEP_DOWN_EN
    input  logic step_down_req_i,
    output logic step_down_ack_o,
`endif
    output logic clk_o
);
    localparam int unsigned Half = Divisor / 2;
    localparam int unsigned CntW = (Half > 1) ? $clog2(Half) : 1;
    localparam logic [CntW-1:0] LimFull = CntW'(Half - 1);

    if (Divisor < 2 || Divisor % 2 != 0) begin : gen_bad_divisor
        $error("prim_clock_div: Divisor must be an even integer >= 2");
    end

    logic [CntW-1:0] cnt_q, cnt_d, lim;
    logic            clk_div_q, clk_div_d, terminal, clk_pre;

    assign terminal = (cnt_q == lim);

    // Count up to lim, then wrap and flip the divided clock.
    always_comb begin
        cnt_d     = terminal ? '0 : cnt_q + 1'b1;
        clk_div_d = terminal ? ~clk_div_q : clk_div_q;
    end

    // Divider state; reset parks the output low immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            clk_div_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_div_q <= clk_div_d;
        end
    end

`ifdef PRIM_CLOCK_DIV_STEP_DOWN_EN
    if (Divisor % 4 != 0) begin : gen_bad_step_divisor
        $error("prim_clock_div: step-down needs Divisor to be a multiple of 4");
    end

    localparam logic [CntW-1:0] LimStep = CntW'(Divisor / 4 - 1);

    typedef enum logic {Full, Step} state_e;
    state_e state_q, state_d;

    // Rate state register; reset always lands in the full-period rate.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= Full;
        else       state_q <= state_d;
    end

    // The request is only honoured on a terminal edge, when cnt is about to be 0.
    always_comb begin
        state_d = terminal ? (step_down_req_i ? Step : Full) : state_q;
    end

    // Rate state selects the half-period limit and drives the acknowledge.
    always_comb begin
        lim             = (state_q == Step) ? LimStep : LimFull;
        step_down_ack_o = (state_q == Step);
    end
`else
    assign lim = LimFull;
`endif

    assign clk_pre = scanmode_i ? clk_i : clk_div_q;

    if (NoFpgaBufG) begin : gen_direct
        assign clk_o = clk_pre;
    end else begin : gen_bufg
        // Behavioural stand-in for the global clock buffer; FPGA flows map this net onto a BUFG.
        assign clk_o = clk_pre;
    end
endmodule
